// File: rtl/bitmask_imm_decoder.sv
// Multi-cycle expander for AArch64/LEGv8 logical immediates (N:immr:imms).
// Builds the run of ones, rotates it one bit per cycle, then doubles it out to 64 bits.
module bitmask_imm_decoder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             n,
  input  logic [5:0]       immr,
  input  logic [5:0]       imms,
  output logic             ready,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] mask,
  output logic             err
);

  if (WIDTH != 64) begin : g_bad_width
    $error("bitmask_imm_decoder supports only WIDTH=64");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_ROTATE    = 3'd2;
  localparam logic [2:0] S_REPLICATE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             n_q, n_d;
  logic [5:0]       immr_q, immr_d;
  logic [5:0]       imms_q, imms_d;
  logic [WIDTH-1:0] elem_q, elem_d;
  logic [6:0]       size_q, size_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             err_q, err_d;

  // Decode of the latched fields: element size is set by the top one of {N, ~imms}.
  logic [6:0]       dec_field;
  logic [2:0]       dec_len;
  logic [5:0]       dec_levels;
  logic [6:0]       dec_esize;
  logic [5:0]       dec_s;
  logic [5:0]       dec_r;
  logic             dec_bad;
  logic [WIDTH-1:0] dec_elem;

  always_comb begin
    dec_field = {n_q, ~imms_q};
    dec_len   = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (dec_field[i]) dec_len = 3'(i);
    end
    dec_levels = 6'((7'd1 << dec_len) - 7'd1);
    dec_esize  = 7'd1 << dec_len;
    dec_s      = imms_q & dec_levels;
    dec_r      = immr_q & dec_levels;
    dec_bad    = (dec_field == 7'd0) || (dec_s == dec_levels);
    dec_elem   = ~({WIDTH{1'b1}} << ({1'b0, dec_s} + 7'd1));
  end

  // Bits above size_q are always zero, so a plain shift/OR stays inside the element.
  logic [WIDTH-1:0] rot_elem;
  logic [WIDTH-1:0] rep_elem;
  logic [6:0]       rep_size;

  always_comb begin
    rot_elem = (elem_q >> 1) | (WIDTH'(elem_q[0]) << (size_q - 7'd1));
    rep_elem = elem_q | (elem_q << size_q);
    rep_size = size_q << 1;
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    immr_d  = immr_q;
    imms_d  = imms_q;
    elem_d  = elem_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          immr_d  = immr;
          imms_d  = imms;
          err_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_bad) begin
          err_d   = 1'b1;
          elem_d  = '0;
          state_d = S_DONE;
        end else begin
          elem_d = dec_elem;
          cnt_d  = dec_r;
          size_d = dec_esize;
          if (dec_r != 6'd0)           state_d = S_ROTATE;
          else if (dec_esize != 7'd64) state_d = S_REPLICATE;
          else                         state_d = S_DONE;
        end
      end
      S_ROTATE: begin
        elem_d = rot_elem;
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = (size_q != 7'd64) ? S_REPLICATE : S_DONE;
        end
      end
      S_REPLICATE: begin
        elem_d = rep_elem;
        size_d = rep_size;
        if (rep_size == 7'd64) state_d = S_DONE;
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result is captured once, on the way into DONE, and then held for the consumer.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      mask_d = err_d ? '0 : elem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= 1'b0;
      immr_q  <= '0;
      imms_q  <= '0;
      elem_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      immr_q  <= immr_d;
      imms_q  <= imms_d;
      elem_q  <= elem_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign valid = (state_q == S_DONE);
  assign mask  = mask_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bitmask_imm_decoder.sv
// Bench for bitmask_imm_decoder: directed cases plus random immediates checked
// against a modular-arithmetic reference of the logical-immediate rules.
module tb_bitmask_imm_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        n;
  logic [5:0]  immr;
  logic [5:0]  imms;
  logic        ready;
  logic        valid;
  logic        ack;
  logic [63:0] mask;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  bitmask_imm_decoder #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .n     (n),
    .immr  (immr),
    .imms  (imms),
    .ready (ready),
    .valid (valid),
    .ack   (ack),
    .mask  (mask),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: element bit i of the rotated run is set when (i+R) mod esize <= S.
  function automatic void model(input bit mn, input bit [5:0] mimmr, input bit [5:0] mimms,
                                output bit [63:0] m, output bit e, output int lat);
    int v, len, esize, s, r;
    bit [63:0] pat;
    bit [5:0] inv;
    inv = ~mimms;
    v = int'(mn) * 64 + int'(inv);
    m = '0;
    pat = '0;
    e = 1'b0;
    lat = 2;
    if (v == 0) begin
      e = 1'b1;
      return;
    end
    len = 0;
    for (int i = 0; i < 7; i++) if (((v >> i) & 1) == 1) len = i;
    esize = 1 << len;
    s = int'(mimms) % esize;
    r = int'(mimmr) % esize;
    if (s == esize - 1) begin
      e = 1'b1;
      return;
    end
    for (int i = 0; i < esize; i++) if (((i + r) % esize) <= s) pat[i] = 1'b1;
    for (int i = 0; i < 64; i++) m[i] = pat[i % esize];
    lat = 2 + r + (6 - len);
  endfunction

  task automatic run_req(input bit rn, input bit [5:0] rimmr, input bit [5:0] rimms,
                         input int hold, input bit busy_noise, input bit start_at_ack);
    bit [63:0] em;
    bit ee;
    int lat, cyc;
    model(rn, rimmr, rimms, em, ee, lat);
    n = rn; immr = rimmr; imms = rimms; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (valid !== 1'b1 && cyc < 100) begin
      if (busy_noise) begin
        start = 1'($urandom_range(0, 1));
        ack   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ack   = 1'b0;
    chk("latency", 64'(cyc), 64'(lat));
    chk("mask", mask, em);
    chk("err", 64'(err), 64'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(valid), 64'd1);
      chk("hold_mask", mask, em);
    end
    ack = 1'b1;
    start = start_at_ack;
    @(posedge clk); #1;
    ack = 1'b0;
    start = 1'b0;
    chk("ready_after_ack", 64'(ready), 64'd1);
    chk("valid_after_ack", 64'(valid), 64'd0);
    @(posedge clk); #1;
    chk("no_second_req", 64'(ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; n = 1'b0; immr = '0; imms = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_mask", mask, 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Directed cases, including known-answer masks.
    run_req(1'b1, 6'd0, 6'b000000, 0, 1'b0, 1'b0);
    chk("kat1", mask, 64'h0000000000000001);
    run_req(1'b0, 6'd0, 6'b000111, 0, 1'b0, 1'b0);
    chk("kat2", mask, 64'h000000FF000000FF);
    run_req(1'b0, 6'b000001, 6'b111100, 0, 1'b1, 1'b1);
    chk("kat3", mask, 64'hAAAAAAAAAAAAAAAA);
    run_req(1'b1, 6'b000100, 6'b000011, 5, 1'b0, 1'b0);
    chk("kat4", mask, 64'hF000000000000000);
    run_req(1'b0, 6'd5, 6'b111111, 1, 1'b0, 1'b0);
    chk("rsv0_err", 64'(err), 64'd1);
    run_req(1'b1, 6'd0, 6'b111111, 0, 1'b0, 1'b0);
    chk("rsv1_err", 64'(err), 64'd1);

    // Reset in ROTATE of the 0xAAAA.. case after a nonzero mask was produced.
    run_req(1'b1, 6'b000100, 6'b000011, 0, 1'b0, 1'b0);
    n = 1'b0; immr = 6'b000001; imms = 6'b111100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_mask", mask, 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    chk("midrst_idle", 64'(ready), 64'd1);
    run_req(1'b0, 6'b000001, 6'b111100, 0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bitmask_imm_decoder.md
Name: bitmask_imm_decoder

Overview:
- Multi-cycle decoder that expands an AArch64/LEGv8 logical immediate (N:immr:imms) into the 64-bit mask consumed by the bitwise AND datapath, the B operand of and_64.
- Sits between instruction decode and the ALU operand mux.
- Builds the element, rotates it one bit per cycle, then replicates it by doubling.
- Uses a ready/valid/ack handshake toward the control FSM.

Parameters:
- WIDTH, 64, datapath width. 64 is the only supported value; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- n  input  1  N field of the immediate.
- immr  input  6  rotate field.
- imms  input  6  size/length field.
- ready  output  1  high only in IDLE.
- valid  output  1  high only in DONE; mask/err are stable while high.
- ack  input  1  consumer accepts the result; meaningful only while valid=1.
- mask  output  64  decoded mask, registered.
- err  output  1  reserved/invalid encoding, registered.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). On reset, whether idle or mid-operation:
  - state=IDLE;
  - ready=1, valid=0, err=0, mask=0;
  - internal element/size/count registers are cleared;
  - any in-flight request is discarded.
- States: IDLE, DECODE, ROTATE, REPLICATE, DONE.
- IDLE:
  - If start=1 at edge k, latch n/immr/imms and go to DECODE; cycle k+1 is in DECODE.
  - If start=0, stay in IDLE.
- DECODE (exactly 1 cycle):
  - len = index of the highest set bit of the 7-bit value {n, ~imms}.
  - levels = (1<<len)-1; S = imms & levels; R = immr & levels; esize = 1<<len.
  - Invalid if {n, ~imms} is zero, or if S == levels. Invalid requests clear mask to 0, set err=1, and go to DONE.
  - Otherwise elem = (S+1) ones in bits [S:0], zero elsewhere; cnt = R; size = esize.
  - Next state is ROTATE if R != 0, else REPLICATE if len < 6, else DONE.
- ROTATE:
  - Each cycle rotates elem right by 1 within the low `size` bits: new bit[size-1] = old bit[0], and bits above size stay 0. Then cnt decrements.
  - Leave after exactly R cycles, to REPLICATE if len < 6, else DONE.
- REPLICATE:
  - Each cycle sets elem[2*size-1:0] = {elem[size-1:0], elem[size-1:0]} and doubles size.
  - Runs exactly 6-len cycles; when size reaches 64, go to DONE.
- DONE:
  - On entry, mask = elem (or 0 if err); valid=1.
  - Outputs hold until ack=1, then go to IDLE the next cycle. valid drops and ready rises together.
  - start is ignored in every state except IDLE.
- Latency: for a valid request accepted at edge k, valid first goes high in cycle k+2+R+(6-len). For an invalid request, valid first goes high in cycle k+2.
- ack:
  - ack while valid=0 is ignored.
  - ack held high continuously releases DONE after its first cycle.
  - A start presented in the same cycle as the releasing ack is not accepted; it must be presented again once ready=1.
- Arithmetic: all widths are unsigned. The rotation never crosses the element boundary during ROTATE. mask is always a full 64-bit replicated pattern.
- X-safety: with no reset, outputs are undefined. After the first reset, no output is ever X.

Test Plan:
- Reset, then start with n=1, immr=0, imms=000000 at edge k -> valid rises in cycle k+2, mask=0x0000000000000001, err=0; ack -> ready=1 next cycle.
- n=0, immr=0, imms=000111 (len=5, 8 ones) -> valid in cycle k+3, mask=0x000000FF000000FF.
- n=0, immr=000001, imms=111100 (esize=2, one rotate, five doublings) -> valid in cycle k+8, mask=0xAAAAAAAAAAAAAAAA.
- n=1, immr=000100, imms=000011 -> valid in cycle k+6, mask=0xF000000000000000; hold ack=0 for 5 cycles, and mask/valid stay stable.
- Reserved encodings: n=0, imms=111111 -> err=1, mask=0, valid in cycle k+2. n=1, imms=111111 -> err=1.
- Assert reset during ROTATE of the third case -> the next cycle shows ready=1, valid=0, mask=0. Start pulses during busy states are ignored (no second result).
